// File: rtl/decode_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_pipe_if
// Description : Bundles the D-stage inputs and the E-stage control outputs of
//               decode_ctrl_pipe.
//               master : drives the instruction side (fetch/hazard logic, bench)
//               slave  : the decode/control pipeline register itself
// Ports       : instr_i[31:0], valid_i, stall_i, flush_i  (master -> slave)
//               ctrl_o[15:0], valid_o, stall_req_o,
//               hilo_busy_o, invalid_o                    (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_ctrl_pipe_if;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [15:0] ctrl_o;
  logic        valid_o;
  logic        stall_req_o;
  logic        hilo_busy_o;
  logic        invalid_o;

  modport master (
    output instr_i, valid_i, stall_i, flush_i,
    input  ctrl_o, valid_o, stall_req_o, hilo_busy_o, invalid_o
  );

  modport slave (
    input  instr_i, valid_i, stall_i, flush_i,
    output ctrl_o, valid_o, stall_req_o, hilo_busy_o, invalid_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_pipe
// Description : MIPS-style D-stage decoder feeding a registered E-stage control
//               bundle, with a HI/LO busy counter that stalls F/D on HI/LO
//               structural hazards after DIV/MULT issue.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               bus.slave  - instr_i/valid_i/stall_i/flush_i in,
//                            ctrl_o/valid_o/stall_req_o/hilo_busy_o/invalid_o out
// ctrl_o      : {regwrite, regdst, alusrc, memtoreg, memwrite, memen, branch,
//                jump, jal, jr, bal, hi_we, lo_we, div_start, mul_start,
//                signed_op}
// Macro       : DECODE_INVALID_EN - when defined, unrecognised instructions
//               raise a registered invalid_o; otherwise invalid_o is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_pipe #(
  parameter int DIV_CYCLES = 36,
  parameter int MUL_CYCLES = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  decode_ctrl_pipe_if.slave  bus
);

  localparam logic [5:0] c_OP_SPECIAL = 6'h00, c_OP_REGIMM = 6'h01, c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL     = 6'h03, c_OP_BEQ    = 6'h04, c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_BLEZ    = 6'h06, c_OP_BGTZ   = 6'h07, c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU   = 6'h09, c_OP_SLTI   = 6'h0A, c_OP_SLTIU = 6'h0B;
  localparam logic [5:0] c_OP_ANDI    = 6'h0C, c_OP_ORI    = 6'h0D, c_OP_XORI  = 6'h0E;
  localparam logic [5:0] c_OP_LUI     = 6'h0F, c_OP_LB     = 6'h20, c_OP_LH    = 6'h21;
  localparam logic [5:0] c_OP_LW      = 6'h23, c_OP_LBU    = 6'h24, c_OP_LHU   = 6'h25;
  localparam logic [5:0] c_OP_SB      = 6'h28, c_OP_SH     = 6'h29, c_OP_SW    = 6'h2B;

  localparam logic [5:0] c_FN_SLL  = 6'h00, c_FN_SRL  = 6'h02, c_FN_SRA   = 6'h03, c_FN_SLLV = 6'h04;
  localparam logic [5:0] c_FN_SRLV = 6'h06, c_FN_SRAV = 6'h07, c_FN_JR    = 6'h08, c_FN_JALR = 6'h09;
  localparam logic [5:0] c_FN_MFHI = 6'h10, c_FN_MTHI = 6'h11, c_FN_MFLO  = 6'h12, c_FN_MTLO = 6'h13;
  localparam logic [5:0] c_FN_MULT = 6'h18, c_FN_MULTU = 6'h19, c_FN_DIV  = 6'h1A, c_FN_DIVU = 6'h1B;
  localparam logic [5:0] c_FN_ADD  = 6'h20, c_FN_ADDU = 6'h21, c_FN_SUB   = 6'h22, c_FN_SUBU = 6'h23;
  localparam logic [5:0] c_FN_AND  = 6'h24, c_FN_OR   = 6'h25, c_FN_XOR   = 6'h26, c_FN_NOR  = 6'h27;
  localparam logic [5:0] c_FN_SLT  = 6'h2A, c_FN_SLTU = 6'h2B;

  localparam logic [4:0] c_RT_BLTZ = 5'h00, c_RT_BGEZ = 5'h01, c_RT_BLTZAL = 5'h10, c_RT_BGEZAL = 5'h11;

  localparam logic [5:0] c_DIV_LOAD     = 6'(DIV_CYCLES);
  localparam logic [5:0] c_MUL_LOAD     = 6'(MUL_CYCLES - 1);
  localparam bit         c_MUL_HAS_BUSY = (MUL_CYCLES > 1);

  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rt;
  logic        w_unused_fields;
  logic        w_known, w_hilo_op, w_no_wb;
  logic        w_regwrite, w_regdst, w_alusrc, w_memtoreg, w_memwrite, w_memen;
  logic        w_branch, w_jump, w_jal, w_jr, w_bal;
  logic        w_hi_we, w_lo_we, w_div_start, w_mul_start, w_signed_op;
  logic [15:0] w_dec;
  logic        w_hilo_busy, w_stall_req, w_bubble, w_accept;

  logic [15:0] r_ctrl;
  logic        r_valid;
  logic [5:0]  r_busy_cnt;

  assign w_opcode        = bus.instr_i[31:26];
  assign w_rt            = bus.instr_i[20:16];
  assign w_funct         = bus.instr_i[5:0];
  assign w_unused_fields = ^{bus.instr_i[25:21], bus.instr_i[15:6]};

  // Every flag is only raised inside a recognised encoding, so an unknown
  // instruction decodes to an all-zero bundle with w_known low.
  always_comb begin
    w_known    = 1'b0; w_hilo_op   = 1'b0; w_no_wb     = 1'b0;
    w_regwrite = 1'b0; w_regdst    = 1'b0; w_alusrc    = 1'b0;
    w_memtoreg = 1'b0; w_memwrite  = 1'b0; w_memen     = 1'b0;
    w_branch   = 1'b0; w_jump      = 1'b0; w_jal       = 1'b0;
    w_jr       = 1'b0; w_bal       = 1'b0; w_hi_we     = 1'b0;
    w_lo_we    = 1'b0; w_div_start = 1'b0; w_mul_start = 1'b0;
    w_signed_op = 1'b0;
    case (w_opcode)
      c_OP_SPECIAL: begin
        case (w_funct)
          c_FN_SLL, c_FN_SRL, c_FN_SRA, c_FN_SLLV, c_FN_SRLV, c_FN_SRAV,
          c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU, c_FN_AND, c_FN_OR,
          c_FN_XOR, c_FN_NOR, c_FN_SLT, c_FN_SLTU, c_FN_MFHI, c_FN_MFLO:
            w_known = 1'b1;
          c_FN_JR:   begin w_known = 1'b1; w_no_wb = 1'b1; w_jump = 1'b1; w_jr = 1'b1; end
          c_FN_JALR: begin w_known = 1'b1; w_jr = 1'b1; end
          c_FN_MTHI: begin w_known = 1'b1; w_no_wb = 1'b1; w_hi_we = 1'b1; end
          c_FN_MTLO: begin w_known = 1'b1; w_no_wb = 1'b1; w_lo_we = 1'b1; end
          c_FN_MULT, c_FN_MULTU: begin
            w_known = 1'b1; w_no_wb = 1'b1; w_hi_we = 1'b1; w_lo_we = 1'b1;
            w_mul_start = 1'b1; w_signed_op = (w_funct == c_FN_MULT);
          end
          c_FN_DIV, c_FN_DIVU: begin
            w_known = 1'b1; w_no_wb = 1'b1; w_hi_we = 1'b1; w_lo_we = 1'b1;
            w_div_start = 1'b1; w_signed_op = (w_funct == c_FN_DIV);
          end
          default: ;
        endcase
        w_hilo_op  = (w_funct >= c_FN_MFHI && w_funct <= c_FN_MTLO) ||
                     (w_funct >= c_FN_MULT && w_funct <= c_FN_DIVU);
        w_regdst   = w_known;
        w_regwrite = w_known & ~w_no_wb;
      end
      c_OP_REGIMM: begin
        case (w_rt)
          c_RT_BLTZ, c_RT_BGEZ:     begin w_known = 1'b1; w_branch = 1'b1; end
          c_RT_BLTZAL, c_RT_BGEZAL: begin
            w_known = 1'b1; w_branch = 1'b1; w_bal = 1'b1; w_regwrite = 1'b1;
          end
          default: ;
        endcase
      end
      c_OP_J:   begin w_known = 1'b1; w_jump = 1'b1; end
      c_OP_JAL: begin w_known = 1'b1; w_jal = 1'b1; w_regwrite = 1'b1; end
      c_OP_BEQ, c_OP_BNE, c_OP_BLEZ, c_OP_BGTZ: begin w_known = 1'b1; w_branch = 1'b1; end
      c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
      c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: begin
        w_known = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
      end
      c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU: begin
        w_known = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1; w_memtoreg = 1'b1; w_memen = 1'b1;
      end
      c_OP_SB, c_OP_SH, c_OP_SW: begin
        w_known = 1'b1; w_alusrc = 1'b1; w_memwrite = 1'b1; w_memen = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_dec = {w_regwrite, w_regdst, w_alusrc, w_memtoreg, w_memwrite, w_memen,
                  w_branch, w_jump, w_jal, w_jr, w_bal,
                  w_hi_we, w_lo_we, w_div_start, w_mul_start, w_signed_op};

  // A flushed instruction never needs HI/LO, so it must not raise a stall.
  assign w_hilo_busy = (r_busy_cnt != 6'd0);
  assign w_stall_req = bus.valid_i & w_hilo_op & w_hilo_busy & ~bus.flush_i;
  assign w_bubble    = bus.flush_i | w_stall_req | ~bus.valid_i;
  assign w_accept    = ~bus.stall_i & ~w_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (bus.stall_i) begin
      r_ctrl  <= r_ctrl;
      r_valid <= r_valid;
    end else if (w_bubble) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ctrl  <= w_dec;
      r_valid <= 1'b1;
    end
  end

  // The counter runs independently of stall/flush: once a HI/LO operation
  // has issued it completes regardless of what happens upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else if (w_accept && w_div_start) begin
      r_busy_cnt <= c_DIV_LOAD;
    end else if (w_accept && w_mul_start && c_MUL_HAS_BUSY) begin
      r_busy_cnt <= c_MUL_LOAD;
    end else if (w_hilo_busy) begin
      r_busy_cnt <= r_busy_cnt - 6'd1;
    end
  end

`ifdef DECODE_INVALID_EN
  logic r_invalid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_invalid <= 1'b0;
    end else if (bus.stall_i) begin
      r_invalid <= r_invalid;
    end else if (w_bubble) begin
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= ~w_known;
    end
  end
  assign bus.invalid_o = r_invalid;
`else
  assign bus.invalid_o = 1'b0;
`endif

  assign bus.ctrl_o      = r_ctrl;
  assign bus.valid_o     = r_valid;
  assign bus.stall_req_o = w_stall_req;
  assign bus.hilo_busy_o = w_hilo_busy;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_pipe
// Description : Self-checking bench for decode_ctrl_pipe. Expected E-stage
//               bundles are queued when an instruction is driven and popped
//               one cycle later; a small counter model predicts stall/busy.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_ctrl_pipe;
  localparam int DIVC = 36;
  localparam int MULC = 1;
`ifdef DECODE_INVALID_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  decode_ctrl_pipe_if bus();
  decode_ctrl_pipe #(.DIV_CYCLES(DIVC), .MUL_CYCLES(MULC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct { logic v; logic inv; logic [15:0] ctrl; string name; } exp_t;
  typedef struct { logic [31:0] instr; logic v, st, fl, r; logic [15:0] dec; logic inv; string name; } step_t;

  exp_t sb[$];
  exp_t last_exp = '{1'b0, 1'b0, 16'h0, "reset"};
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  logic exp_sreq, exp_busy;

  localparam logic [31:0] I_ADDI = 32'h2008_0005, I_SW = 32'hAC08_0000, I_LW = 32'h8C08_0000;
  localparam logic [31:0] I_ADDU = 32'h0085_4021, I_JAL = 32'h0C00_0010, I_J = 32'h0800_0010;
  localparam logic [31:0] I_JR = 32'h03E0_0008, I_JALR = 32'h0060_F809, I_BEQ = 32'h1109_0004;
  localparam logic [31:0] I_BGEZAL = 32'h0411_0004, I_BLTZ = 32'h0400_0004, I_DIV = 32'h0109_001A;
  localparam logic [31:0] I_MULTU = 32'h0109_0019, I_MFLO = 32'h0000_4012, I_MFHI = 32'h0000_4010;
  localparam logic [31:0] I_MTHI = 32'h0100_0011, I_LUI = 32'h3C08_1234, I_SB = 32'hA108_0000;
  localparam logic [31:0] I_BAD = 32'hFC00_0000, I_NOP = 32'h0000_0000;

  function automatic logic is_hilo(input logic [31:0] ins);
    logic [5:0] f;
    f = ins[5:0];
    return (ins[31:26] == 6'h00) && (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  // Drive one D-stage cycle, queue the bundle expected on the next edge and
  // advance the busy-counter model. Returns 1ns after driving.
  task automatic drive(input step_t s);
    exp_t e;
    logic bub;
    bus.instr_i = s.instr; bus.valid_i = s.v; bus.stall_i = s.st; bus.flush_i = s.fl; rst = s.r;
    exp_busy = (m_cnt != 0);
    exp_sreq = s.v & is_hilo(s.instr) & exp_busy & ~s.fl;
    bub = s.fl | exp_sreq | ~s.v;
    if (s.r)       e = '{1'b0, 1'b0, 16'h0, ""};
    else if (s.st) e = last_exp;
    else if (bub)  e = '{1'b0, 1'b0, 16'h0, ""};
    else           e = '{1'b1, s.inv & INV_EN, s.dec, ""};
    if (s.r) m_cnt = 0;
    else if (!s.st && !bub && s.dec[2]) m_cnt = DIVC;
    else if (!s.st && !bub && s.dec[1] && MULC > 1) m_cnt = MULC - 1;
    else if (m_cnt != 0) m_cnt = m_cnt - 1;
    last_exp = e;
    e.name = s.name;
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    step_t t[2] = '{'{I_ADDI, 1, 0, 0, 1, 16'hA000, 0, "rst0"}, '{I_DIV, 1, 0, 0, 1, 16'h401D, 0, "rst1"}};
    exp_t e;
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({bus.valid_o, bus.invalid_o, bus.ctrl_o, bus.hilo_busy_o, bus.stall_req_o} !== {e.v, e.inv, e.ctrl, 2'b00}) begin
        n_fail++;
        $display("FAIL %s: got v=%b inv=%b ctrl=%h busy=%b sreq=%b, expected all zero", e.name,
                 bus.valid_o, bus.invalid_o, bus.ctrl_o, bus.hilo_busy_o, bus.stall_req_o);
      end
    end
  endtask

  task automatic test_decode();
    step_t t[19] = '{
      '{I_ADDI, 1, 0, 0, 0, 16'hA000, 0, "addi"},   '{I_SW, 1, 0, 0, 0, 16'h2C00, 0, "sw"},
      '{I_LW, 1, 0, 0, 0, 16'hB400, 0, "lw"},       '{I_ADDU, 1, 0, 0, 0, 16'hC000, 0, "addu"},
      '{I_JAL, 1, 0, 0, 0, 16'h8080, 0, "jal"},     '{I_J, 1, 0, 0, 0, 16'h0100, 0, "j"},
      '{I_JR, 1, 0, 0, 0, 16'h4140, 0, "jr"},       '{I_JALR, 1, 0, 0, 0, 16'hC040, 0, "jalr"},
      '{I_BEQ, 1, 0, 0, 0, 16'h0200, 0, "beq"},     '{I_BGEZAL, 1, 0, 0, 0, 16'h8220, 0, "bgezal"},
      '{I_BLTZ, 1, 0, 0, 0, 16'h0200, 0, "bltz"},   '{I_NOP, 0, 0, 0, 0, 16'hC000, 0, "novalid"},
      '{I_MTHI, 1, 0, 0, 0, 16'h4010, 0, "mthi"},   '{I_LUI, 1, 0, 0, 0, 16'hA000, 0, "lui"},
      '{I_SB, 1, 0, 0, 0, 16'h2C00, 0, "sb"},       '{I_MULTU, 1, 0, 0, 0, 16'h401A, 0, "multu"},
      '{I_MFHI, 1, 0, 0, 0, 16'hC000, 0, "mfhi_b2b"}, '{I_NOP, 1, 0, 0, 0, 16'hC000, 0, "nop"},
      '{I_BAD, 1, 0, 0, 0, 16'h0000, 1, "op3f"}};
    exp_t e;
    foreach (t[i]) begin
      drive(t[i]);
      n_checks++;
      if ({bus.stall_req_o, bus.hilo_busy_o} !== {exp_sreq, exp_busy}) begin
        n_fail++;
        $display("FAIL %s sreq/busy: got %b%b expected %b%b", t[i].name, bus.stall_req_o, bus.hilo_busy_o, exp_sreq, exp_busy);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({bus.valid_o, bus.invalid_o, bus.ctrl_o} !== {e.v, e.inv, e.ctrl}) begin
        n_fail++;
        $display("FAIL %s: got v=%b inv=%b ctrl=%h expected v=%b inv=%b ctrl=%h", e.name,
                 bus.valid_o, bus.invalid_o, bus.ctrl_o, e.v, e.inv, e.ctrl);
      end
    end
  endtask

  // DIV then MFLO held in D: MFLO must stall for exactly DIV_CYCLES cycles.
  task automatic test_div_mflo();
    step_t s;
    exp_t e;
    int n_sreq = 0;
    s = '{I_NOP, 0, 0, 0, 1, 16'h0, 0, "dm_rst"}; drive(s); @(negedge clk); void'(sb.pop_front());
    s = '{I_DIV, 1, 0, 0, 0, 16'h401D, 0, "div"};
    for (int c = 0; c < 40; c++) begin
      drive(s);
      n_checks++;
      if ({bus.stall_req_o, bus.hilo_busy_o} !== {exp_sreq, exp_busy}) begin
        n_fail++;
        $display("FAIL %s c%0d sreq/busy: got %b%b expected %b%b", s.name, c, bus.stall_req_o, bus.hilo_busy_o, exp_sreq, exp_busy);
      end
      if (bus.stall_req_o === 1'b1) n_sreq++;
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({bus.valid_o, bus.ctrl_o} !== {e.v, e.ctrl}) begin
        n_fail++;
        $display("FAIL %s c%0d: got v=%b ctrl=%h expected v=%b ctrl=%h", e.name, c, bus.valid_o, bus.ctrl_o, e.v, e.ctrl);
      end
      if (c > 0 && e.v) break;
      s = '{I_MFLO, 1, 0, 0, 0, 16'hC000, 0, "mflo"};
    end
    n_checks++;
    if (n_sreq !== DIVC) begin
      n_fail++;
      $display("FAIL div_mflo stall count: got %0d expected %0d", n_sreq, DIVC);
    end
  endtask

  // JAL loaded, ADDU held by stall_i for 3 cycles while the divide count runs.
  task automatic test_stall();
    step_t t[7] = '{
      '{I_NOP, 0, 0, 0, 1, 16'h0, 0, "st_rst"},  '{I_DIV, 1, 0, 0, 0, 16'h401D, 0, "st_div"},
      '{I_JAL, 1, 0, 0, 0, 16'h8080, 0, "st_jal"}, '{I_ADDU, 1, 1, 0, 0, 16'hC000, 0, "st_hold1"},
      '{I_ADDU, 1, 1, 0, 0, 16'hC000, 0, "st_hold2"}, '{I_ADDU, 1, 1, 0, 0, 16'hC000, 0, "st_hold3"},
      '{I_ADDU, 1, 0, 0, 0, 16'hC000, 0, "st_addu"}};
    step_t s;
    exp_t e;
    int n_sreq = 0;
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({bus.valid_o, bus.ctrl_o, bus.hilo_busy_o} !== {e.v, e.ctrl, (m_cnt != 0)}) begin
        n_fail++;
        $display("FAIL %s: got v=%b ctrl=%h busy=%b expected v=%b ctrl=%h busy=%b", e.name,
                 bus.valid_o, bus.ctrl_o, bus.hilo_busy_o, e.v, e.ctrl, (m_cnt != 0));
      end
    end
    s = '{I_MFLO, 1, 0, 0, 0, 16'hC000, 0, "st_mflo"};
    for (int c = 0; c < 64; c++) begin
      drive(s);
      if (bus.stall_req_o === 1'b1) n_sreq++;
      @(negedge clk);
      e = sb.pop_front();
      if (e.v) begin
        n_checks++;
        if (bus.ctrl_o !== 16'hC000 || bus.valid_o !== 1'b1) begin
          n_fail++;
          $display("FAIL st_mflo load: got v=%b ctrl=%h expected v=1 ctrl=c000", bus.valid_o, bus.ctrl_o);
        end
        break;
      end
    end
    // DIV->36, JAL->35, three stalls->32, ADDU->31: MFLO waits 31 cycles.
    n_checks++;
    if (n_sreq !== DIVC - 5) begin
      n_fail++;
      $display("FAIL stall_decrement count: got %0d expected %0d", n_sreq, DIVC - 5);
    end
  endtask

  // Flush kills JAL and a busy-time MFLO; reset mid-count clears busy at once.
  task automatic test_flush_reset();
    step_t t[7] = '{
      '{I_NOP, 0, 0, 0, 1, 16'h0, 0, "fl_rst"},     '{I_JAL, 1, 0, 1, 0, 16'h8080, 0, "fl_jal"},
      '{I_DIV, 1, 0, 0, 0, 16'h401D, 0, "fl_div"},  '{I_MFLO, 1, 0, 1, 0, 16'hC000, 0, "fl_mflo"},
      '{I_NOP, 0, 0, 0, 0, 16'h0, 0, "fl_idle"},    '{I_MFLO, 1, 0, 0, 1, 16'hC000, 0, "fl_rst_busy"},
      '{I_MFLO, 1, 0, 0, 0, 16'hC000, 0, "fl_mflo_free"}};
    step_t idle = '{I_NOP, 0, 0, 0, 0, 16'h0, 0, "fl_wait"};
    exp_t e;
    foreach (t[i]) begin
      drive(t[i]);
      n_checks++;
      if ({bus.stall_req_o, bus.hilo_busy_o} !== {exp_sreq, exp_busy}) begin
        n_fail++;
        $display("FAIL %s sreq/busy: got %b%b expected %b%b", t[i].name, bus.stall_req_o, bus.hilo_busy_o, exp_sreq, exp_busy);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({bus.valid_o, bus.ctrl_o} !== {e.v, e.ctrl}) begin
        n_fail++;
        $display("FAIL %s: got v=%b ctrl=%h expected v=%b ctrl=%h", e.name, bus.valid_o, bus.ctrl_o, e.v, e.ctrl);
      end
      // Run the divide count down to 20 before the reset step.
      if (t[i].name == "fl_idle") begin
        while (m_cnt > 20) begin drive(idle); @(negedge clk); void'(sb.pop_front()); end
        n_checks++;
        if (bus.hilo_busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fl_count20 busy: got %b expected 1", bus.hilo_busy_o);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_i = '0; bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_decode();
    test_div_mflo();
    test_stall();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 Parameter DIV_CYCLES, default 36: cycles the HI/LO unit is busy after a DIV/DIVU issues; legal range 1..63.
REQ-002 Parameter MUL_CYCLES, default 1: cycles the HI/LO unit is busy after a MULT/MULTU issues; 1 means no busy window; legal range 1..63.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 instr_i  in  32  D-stage instruction word.
REQ-006 valid_i  in  1  instr_i holds a real instruction.
REQ-007 stall_i  in  1  external hazard-unit stall; hold the E register.
REQ-008 flush_i  in  1  kill the D-stage instruction.
REQ-009 ctrl_o  out  16  registered E-stage bundle, MSB..LSB: regwrite, regdst, alusrc, memtoreg, memwrite, memen, branch, jump, jal, jr, bal, hi_we, lo_we, div_start, mul_start, signed_op.
REQ-010 valid_o  out  1  ctrl_o describes a real instruction.
REQ-011 stall_req_o  out  1  combinational request to stall F/D on a HI/LO structural hazard.
REQ-012 hilo_busy_o  out  1  busy counter non-zero.
REQ-013 invalid_o  out  1  registered reserved-instruction flag (see Configuration).

Function
REQ-014 Decode SHALL be combinational from instr_i: opcode [31:26], rt [20:16], funct [5:0].
REQ-015 Decode: regwrite for ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU/JAL/BLTZAL/BGEZAL/LB/LBU/LH/LHU/LW, and for SPECIAL except MTHI/MTLO/MULT/MULTU/DIV/DIVU/JR.
REQ-016 Decode: regdst for SPECIAL; alusrc for immediate ALU ops and all loads/stores; memtoreg for loads; memwrite for SB/SH/SW; memen for all loads/stores.
REQ-017 Decode: branch for BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/BLTZAL/BGEZAL; jump for J/JR; jal for JAL; jr for JR/JALR; bal for BLTZAL/BGEZAL.
REQ-018 Decode: hi_we/lo_we for MULT/MULTU/DIV/DIVU, plus hi_we for MTHI and lo_we for MTLO; div_start for DIV/DIVU; mul_start for MULT/MULTU; signed_op for DIV/MULT.
REQ-019 hilo_op = SPECIAL with funct MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU.
REQ-020 stall_req_o SHALL equal valid_i & hilo_op & hilo_busy_o & ~flush_i.
REQ-021 Each edge, priority: rst > stall_i (hold ctrl_o, valid_o, invalid_o) > flush_i or stall_req_o or ~valid_i (load bubble: all zeros) > load decoded bundle with valid_o=1.
REQ-022 Busy counter (6 bits): on an edge where a bundle with div_start loads, set to DIV_CYCLES; with mul_start and MUL_CYCLES>1, set to MUL_CYCLES-1; else decrement if non-zero, saturating at 0.
REQ-023 Counter SHALL keep decrementing during stall_i and flush_i; flush never aborts an issued operation.
REQ-024 Latency: decoded D-stage instruction appears on ctrl_o one cycle after acceptance; no combinational path instr_i -> ctrl_o.

Reset
REQ-025 On rst high at an edge: ctrl_o=0, valid_o=0, invalid_o=0, counter=0; stall_req_o is therefore 0 the next cycle.
REQ-026 Reset mid-divide SHALL clear the counter immediately; no residual busy.

Configuration
REQ-027 Macro DECODE_INVALID_EN: defined -> any valid opcode/funct/rt combination outside REQ-015..018 and not NOP/SLL/SRL/SRA/etc. SPECIAL ALU ops loads invalid_o=1 with ctrl_o=0 and valid_o=1; undefined -> invalid_o tied 0, unknown instructions load ctrl_o=0 with valid_o=1.

Verification
REQ-028 rst, then ADDI 0x2008_0005 valid -> next cycle ctrl_o regwrite=1, alusrc=1, regdst=0, valid_o=1.
REQ-029 SW 0xAC08_0000 -> memwrite=1, memen=1, alusrc=1, regwrite=0.
REQ-030 DIV (funct 0x1A) then MFLO (funct 0x12) back-to-back, DIV_CYCLES=36 -> stall_req_o high exactly 36 cycles, bubbles on ctrl_o, MFLO loads cycle 37.
REQ-031 stall_i high 3 cycles with ADDU in D -> ctrl_o unchanged 3 cycles; counter still decrements.
REQ-032 flush_i with JAL in D -> bubble, valid_o=0; rst during busy count 20 -> hilo_busy_o=0 next cycle.
REQ-033 With DECODE_INVALID_EN, opcode 0x3F -> invalid_o=1, ctrl_o=0; without -> invalid_o=0.
